// File: rtl/cpu_defs.sv
// rtl/cpu_defs.sv - shared fetch-front constants, redirect classes and FSM states
//   DEF_RESET_VEC : default PC after reset
//   DEF_EXC_VEC   : default exception entry address
//   rdr_cls_e     : redirect class, numerically ordered by priority
//   fsm_state_e   : fetch FSM states
package cpu_defs;

  parameter logic [31:0] DEF_RESET_VEC = 32'hbfc00000;
  parameter logic [31:0] DEF_EXC_VEC   = 32'hbfc00380;

  // Encoding order is the priority order; the pending register compares classes with >=.
  typedef enum logic [1:0] {
    RDR_NONE = 2'd0,
    RDR_BR   = 2'd1,
    RDR_ERET = 2'd2,
    RDR_EXC  = 2'd3
  } rdr_cls_e;

  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } fsm_state_e;

endpackage

// File: rtl/redirect_hold.sv
// rtl/redirect_hold.sv - pending redirect register with overwrite-by-class
//   clk, rst      : clock, synchronous active-high reset
//   advance       : fetch advances this cycle; consumes/clears the pending entry
//   new_cls       : highest-class live redirect this cycle (RDR_NONE if none)
//   new_tgt       : target of that live redirect
//   pend_valid    : a deferred redirect is held
//   pend_tgt      : its target
module redirect_hold
  import cpu_defs::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             advance,
  input  rdr_cls_e         new_cls,
  input  logic [WIDTH-1:0] new_tgt,
  output logic             pend_valid,
  output logic [WIDTH-1:0] pend_tgt
);

  logic             pend_valid_q, pend_valid_d;
  rdr_cls_e         pend_cls_q, pend_cls_d;
  logic [WIDTH-1:0] pend_tgt_q, pend_tgt_d;

  always_comb begin
    pend_valid_d = pend_valid_q;
    pend_cls_d   = pend_cls_q;
    pend_tgt_d   = pend_tgt_q;
    if (advance) begin
      // A live redirect in an advance cycle is applied directly, so nothing is kept.
      pend_valid_d = 1'b0;
    end else if (new_cls != RDR_NONE && (!pend_valid_q || new_cls >= pend_cls_q)) begin
      // Equal class overwrites: the most recent redirect of a class wins.
      pend_valid_d = 1'b1;
      pend_cls_d   = new_cls;
      pend_tgt_d   = new_tgt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_valid_q <= 1'b0;
      pend_cls_q   <= RDR_NONE;
      pend_tgt_q   <= '0;
    end else begin
      pend_valid_q <= pend_valid_d;
      pend_cls_q   <= pend_cls_d;
      pend_tgt_q   <= pend_tgt_d;
    end
  end

  assign pend_valid = pend_valid_q;
  assign pend_tgt   = pend_tgt_q;

endmodule

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - fetch PC generator with prioritized and deferred redirects
//   clk, rst           : clock, synchronous active-high reset
//   stall              : downstream hold, blocks advance
//   exc_valid          : redirect to EXC_VEC
//   eret_valid, epc    : redirect to epc
//   br_valid, br_target: redirect to br_target
//   inst_req/inst_addr : fetch request and address (address == pc)
//   inst_addr_ok       : memory accepted the address this cycle
//   pc, pc_adel        : current fetch PC and its misalignment flag
module pc_gen
  import cpu_defs::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(DEF_RESET_VEC),
  parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'(DEF_EXC_VEC),
  parameter int               INC       = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             exc_valid,
  input  logic             eret_valid,
  input  logic [WIDTH-1:0] epc,
  input  logic             br_valid,
  input  logic [WIDTH-1:0] br_target,
  output logic             inst_req,
  output logic [WIDTH-1:0] inst_addr,
  input  logic             inst_addr_ok,
  output logic [WIDTH-1:0] pc,
  output logic             pc_adel
);

  fsm_state_e       state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             pc_adel_q, pc_adel_d;

  rdr_cls_e         live_cls;
  logic [WIDTH-1:0] live_tgt;
  logic             advance;
  logic             pend_valid;
  logic [WIDTH-1:0] pend_tgt;

  assign inst_req = (state_q == ST_RUN);
  assign advance  = inst_req & inst_addr_ok & ~stall;

  // Collapse simultaneous redirects to the single highest class.
  always_comb begin
    live_cls = RDR_NONE;
    live_tgt = '0;
    if (exc_valid) begin
      live_cls = RDR_EXC;
      live_tgt = EXC_VEC;
    end else if (eret_valid) begin
      live_cls = RDR_ERET;
      live_tgt = epc;
    end else if (br_valid) begin
      live_cls = RDR_BR;
      live_tgt = br_target;
    end
  end

  redirect_hold #(.WIDTH(WIDTH)) u_hold (
    .clk        (clk),
    .rst        (rst),
    .advance    (advance),
    .new_cls    (live_cls),
    .new_tgt    (live_tgt),
    .pend_valid (pend_valid),
    .pend_tgt   (pend_tgt)
  );

  always_comb begin
    state_d = ST_RUN;
    pc_d    = pc_q;
    if (advance) begin
      if (live_cls != RDR_NONE) begin
        pc_d = live_tgt;
      end else if (pend_valid) begin
        pc_d = pend_tgt;
      end else begin
        pc_d = pc_q + WIDTH'(INC);
      end
    end
    pc_adel_d = (pc_d[1:0] != 2'b00);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_BOOT;
      pc_q      <= RESET_VEC;
      pc_adel_q <= (RESET_VEC[1:0] != 2'b00);
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pc_adel_q <= pc_adel_d;
    end
  end

  assign pc        = pc_q;
  assign inst_addr = pc_q;
  assign pc_adel   = pc_adel_q;

endmodule

// File: tb/tb_pc_gen.sv
// tb/tb_pc_gen.sv - scoreboard bench for pc_gen
module tb_pc_gen;

  localparam logic [31:0] RV = 32'hbfc00000;
  localparam logic [31:0] EV = 32'hbfc00380;

  logic        clk = 1'b0;
  logic        rst, stall, exc_valid, eret_valid, br_valid, inst_addr_ok;
  logic [31:0] epc, br_target;
  logic        inst_req, pc_adel;
  logic [31:0] inst_addr, pc;

  logic        req16, adel16;
  logic [15:0] addr16, pc16;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pc_gen dut (
    .clk(clk), .rst(rst), .stall(stall), .exc_valid(exc_valid),
    .eret_valid(eret_valid), .epc(epc), .br_valid(br_valid), .br_target(br_target),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .pc(pc), .pc_adel(pc_adel)
  );

  pc_gen #(.WIDTH(16), .RESET_VEC(16'hfffc), .EXC_VEC(16'h0380), .INC(4)) dut16 (
    .clk(clk), .rst(rst), .stall(1'b0), .exc_valid(1'b0),
    .eret_valid(1'b0), .epc(16'h0), .br_valid(1'b0), .br_target(16'h0),
    .inst_req(req16), .inst_addr(addr16), .inst_addr_ok(1'b1),
    .pc(pc16), .pc_adel(adel16)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: fetch is either booting or running; redirects reduce to
  // the strongest class present, and a held redirect is replaced only by one
  // at least as strong.
  typedef struct packed { logic req; logic [31:0] pc; logic adel; } exp_t;
  exp_t        sb_q[$];
  bit          m_run = 0;
  logic [31:0] m_pc = RV;
  bit          m_pv = 0;
  int          m_pcls = 0;
  logic [31:0] m_ptgt = '0;

  always @(posedge clk) begin
    int          cls;
    logic [31:0] tgt;
    exp_t        e;
    cls = 0;
    tgt = '0;
    if (br_valid)   begin cls = 1; tgt = br_target; end
    if (eret_valid) begin cls = 2; tgt = epc;       end
    if (exc_valid)  begin cls = 3; tgt = EV;        end
    if (rst) begin
      m_run = 0; m_pc = RV; m_pv = 0;
    end else begin
      if (m_run && inst_addr_ok && !stall) begin
        if (cls > 0)   m_pc = tgt;
        else if (m_pv) m_pc = m_ptgt;
        else           m_pc = m_pc + 32'd4;
        m_pv = 0;
      end else if (cls > 0 && (!m_pv || cls >= m_pcls)) begin
        m_pv = 1; m_pcls = cls; m_ptgt = tgt;
      end
      m_run = 1;
    end
    e.req  = m_run;
    e.pc   = m_pc;
    e.adel = (m_pc % 4) != 0;
    sb_q.push_back(e);
  end

  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("sb_req",  32'(inst_req),  32'(e.req));
      chk("sb_pc",   pc,             e.pc);
      chk("sb_addr", inst_addr,      e.pc);
      chk("sb_adel", 32'(pc_adel),   32'(e.adel));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    exc_valid = 0; eret_valid = 0; br_valid = 0;
  endtask

  initial begin
    logic [31:0] held;
    rst = 1; stall = 0; clr(); epc = '0; br_target = '0; inst_addr_ok = 1;
    cyc(); cyc();
    chk("reset_req", 32'(inst_req), 32'd0);
    chk("reset_pc", pc, RV);
    chk("reset_adel", 32'(pc_adel), 32'd0);
    rst = 0;
    chk("boot_req", 32'(inst_req), 32'd0);
    cyc();
    chk("run_req", 32'(inst_req), 32'd1);
    chk("pc0", pc, 32'hbfc00000);
    chk("w16_pc0", 32'(pc16), 32'h0000fffc);
    cyc();
    chk("pc1", pc, 32'hbfc00004);
    chk("w16_wrap", 32'(pc16), 32'h00000000);
    chk("w16_adel", 32'(adel16), 32'd0);
    cyc();
    chk("pc2", pc, 32'hbfc00008);

    // Branch in an advance cycle
    br_valid = 1; br_target = 32'hbfc00100;
    cyc(); clr();
    chk("br_pc", pc, 32'hbfc00100);
    cyc();
    chk("br_nopend", pc, 32'hbfc00104);

    // Branch captured during a 3-cycle stall
    stall = 1; br_valid = 1; br_target = 32'hbfc00200;
    cyc(); clr();
    chk("stall_c1", pc, 32'hbfc00104);
    cyc(); chk("stall_c2", pc, 32'hbfc00104);
    cyc(); chk("stall_c3", pc, 32'hbfc00104);
    stall = 0;
    cyc(); chk("defer_br", pc, 32'hbfc00200);
    cyc(); chk("defer_seq", pc, 32'hbfc00204);

    // Held exception outranks a later branch
    stall = 1; exc_valid = 1;
    cyc(); clr(); br_valid = 1; br_target = 32'hbfc00300;
    cyc(); clr(); stall = 0;
    cyc(); chk("exc_keeps", pc, EV);

    // Simultaneous exception and eret, then eret alone
    exc_valid = 1; eret_valid = 1; epc = 32'hbfc00010;
    cyc(); clr();
    chk("exc_over_eret", pc, EV);
    eret_valid = 1;
    cyc(); clr();
    chk("eret", pc, 32'hbfc00010);

    // Misaligned target
    br_valid = 1; br_target = 32'hbfc00102;
    cyc(); clr();
    chk("adel_pc", pc, 32'hbfc00102);
    chk("adel_flag", 32'(pc_adel), 32'd1);

    // Memory not accepting for 4 cycles
    held = inst_addr;
    inst_addr_ok = 0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("ok0_addr", inst_addr, held);
      chk("ok0_req", 32'(inst_req), 32'd1);
    end
    inst_addr_ok = 1;
    cyc(); chk("ok1_adv", pc, held + 32'd4);

    // Reset during a stall with a redirect pending
    stall = 1; br_valid = 1; br_target = 32'hbfc00500;
    cyc(); clr(); rst = 1;
    cyc();
    chk("rst_mid_pc", pc, RV);
    chk("rst_mid_req", 32'(inst_req), 32'd0);
    rst = 0; stall = 0;
    cyc(); cyc();
    chk("rst_pend_lost", pc, RV + 32'd4);

    // Randomized traffic, checked by the scoreboard
    for (int i = 0; i < 3000; i++) begin
      stall        = ($urandom % 4) == 0;
      inst_addr_ok = ($urandom % 4) != 0;
      exc_valid    = ($urandom % 16) == 0;
      eret_valid   = ($urandom % 12) == 0;
      br_valid     = ($urandom % 5) == 0;
      epc          = $urandom & 32'hfffffffc;
      br_target    = (($urandom % 8) == 0) ? $urandom : ($urandom & 32'hfffffffc);
      rst          = ($urandom % 250) == 0;
      cyc();
    end
    rst = 0; clr(); stall = 0; inst_addr_ok = 1;
    cyc(); cyc();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised fetch-address generator at the front of the IF stage, successor to the plain PC register. It holds the current fetch PC and issues it on a req/addr_ok handshake to the instruction-memory port. It selects the next PC by fixed priority: exception, eret, branch/jump, deferred redirect, sequential. Redirects that arrive while fetch cannot advance are captured and applied at the next advance, so none is lost to a stall.

## Interface
- `WIDTH`, 32: address width.
- `RESET_VEC`, 32'hbfc00000: PC value after reset.
- `EXC_VEC`, 32'hbfc00380: exception entry address.
- `INC`, 4: sequential increment in bytes.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `stall` in 1: downstream hold; blocks advance.
- `exc_valid` in 1: exception redirect to `EXC_VEC`.
- `eret_valid` in 1: return redirect to `epc`.
- `epc` in WIDTH: eret target.
- `br_valid` in 1: branch/jump redirect.
- `br_target` in WIDTH: branch target.
- `inst_req` out 1: fetch request valid.
- `inst_addr` out WIDTH: fetch address, always equal to `pc`.
- `inst_addr_ok` in 1: memory accepted the address this cycle.
- `pc` out WIDTH: current fetch PC.
- `pc_adel` out 1: current `pc` is misaligned (low 2 bits ≠ 0).

## Operation
- Two-state FSM:
  - BOOT: reset state, `inst_req`=0. Goes to RUN unconditionally on the next cycle.
  - RUN: `inst_req`=1.
- advance = RUN & `inst_req` & `inst_addr_ok` & ~`stall`.
- Next-PC priority on advance:
  1. `exc_valid` → `EXC_VEC`
  2. `eret_valid` → `epc`
  3. `br_valid` → `br_target`
  4. pending valid → pending target
  5. otherwise → `pc` + `INC`, modulo 2^WIDTH, wrap silently
- Pending register holds `pend_valid`, `pend_cls` (2-bit: EXC=3, ERET=2, BR=1) and `pend_tgt`.
  - Redirect while not advancing: write pending if not `pend_valid`, or if the new class ≥ `pend_cls`. Otherwise drop the new one.
  - Several redirects in one cycle: only the highest class is considered.
  - Any advance clears `pend_valid`. A live redirect that cycle outranks pending and consumes it as well.
- Redirects are also accepted in BOOT, into pending.
- Redirects never change `pc` without an advance. `inst_addr` stays stable while `inst_req` is high and `inst_addr_ok` is low.
- `pc_adel` = `pc`[1:0]≠0, registered together with `pc`. The PC is still issued; the exception is raised downstream.
- `rst` has priority over everything and clears pending.

## Timing
- Reset values: `pc`=`RESET_VEC`, `inst_req`=0, `pc_adel`=RESET_VEC[1:0]≠0, `pend_valid`=0, FSM=BOOT.
- First cycle after `rst` falls: `inst_req`=0. Second cycle: `inst_req`=1 with `inst_addr`=`RESET_VEC`.
- Redirect latency: a redirect asserted in an advance cycle gives the new `pc` in the next cycle (1 cycle).
- A deferred redirect appears the cycle after the first subsequent advance.
- `stall` and `inst_addr_ok` both low: hold and capture, no change.
- `rst` asserted mid-stall with pending valid: next cycle is the reset state, pending lost.

## Structure
- Shared package `cpu_defs`: `RESET_VEC`/`EXC_VEC` constants, redirect class encodings (`RDR_NONE`/`RDR_BR`/`RDR_ERET`/`RDR_EXC`), FSM state typedef.
- One sub-module `redirect_hold`: holds the pending register plus its overwrite-by-class logic. The top holds the FSM, next-PC mux and output registers.

## Test plan
- Reset release, `inst_addr_ok`=1: `inst_req` 0 in the first cycle, then `pc` = bfc00000, bfc00004, bfc00008 on consecutive cycles.
- `br_valid` with `br_target`=bfc00100 in an advance cycle → next `pc`=bfc00100, no pending left.
- `stall`=1 for 3 cycles, `br_valid` pulsed at bfc00200 in cycle 1, `stall` drops → `pc` unchanged during the stall, then bfc00200, then bfc00204.
- Stalled: `exc_valid` in cycle 1, then `br_valid` at bfc00300 in cycle 2, release → `pc`=bfc00380 (branch dropped).
- `exc_valid` and `eret_valid` (`epc`=bfc00010) in the same advance cycle → `pc`=bfc00380. Repeat with `eret_valid` alone → bfc00010.
- `br_target`=bfc00102 → `pc_adel`=1 in the same cycle `pc` shows bfc00102. WIDTH=16, `pc`=fffc, sequential → 0000.
- `inst_addr_ok`=0 for 4 cycles → `inst_addr` stable, `inst_req` held at 1.
